// File: rtl/count_wrap_tracker.sv
// count_wrap_tracker: follows a CW-bit up/down counter and extends it with an
// epoch that counts wrap-arounds, so ext_count = {epoch, count} keeps growing
// (modulo 2^(CW+EW)). Each wrap is queued in a small first-word-fall-through
// FIFO and drained over a valid/ready handshake. Sticky flags report illegal
// steps, epoch overflow and events lost to a full FIFO.
//
// Ports:
//   clk        rising-edge clock shared with the counter
//   reset      asynchronous active-low reset
//   count      counter value, sampled every edge
//   resync     the change seen at this edge is a load/reset of the counter
//   clr        synchronous clear of the sticky flags
//   ext_count  {epoch, last sampled count}
//   evt_valid  event FIFO non-empty
//   evt_ready  consumer takes the head entry
//   evt_dir    head entry direction (1 = up wrap, 0 = down wrap)
//   evt_epoch  head entry epoch after the wrap
//   step_err   sticky: non-resync change other than +/-1
//   epoch_ovf  sticky: epoch itself wrapped
//   evt_drop   sticky: event discarded because the FIFO was full
module count_wrap_tracker #(
  parameter int unsigned CW    = 4,
  parameter int unsigned EW    = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CW-1:0]    count,
  input  logic             resync,
  input  logic             clr,
  output logic [CW+EW-1:0] ext_count,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             evt_dir,
  output logic [EW-1:0]    evt_epoch,
  output logic             step_err,
  output logic             epoch_ovf,
  output logic             evt_drop
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW = AW + 1;
  localparam int unsigned DW = EW + 1;
  localparam logic [CW-1:0] MAXC = '1;
  localparam logic [EW-1:0] MAXE = '1;

  logic [CW-1:0] cnt_q, cnt_n;
  logic [EW-1:0] epoch_q, epoch_n;
  logic          primed_q;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, rd_n, wr_ptr, wr_n;
  logic [OW-1:0] occ, occ_n;
  logic          valid_n, dir_n;
  logic [EW-1:0] head_ep_n;

  logic          push, push_dir, set_step, set_ovf;
  logic [EW-1:0] push_ep;
  logic          pop, full, do_push, drop;

  // Classify the sampled change against the previous registered count
  always_comb begin
    cnt_n    = cnt_q;
    epoch_n  = epoch_q;
    push     = 1'b0;
    push_dir = 1'b0;
    push_ep  = epoch_q;
    set_step = 1'b0;
    set_ovf  = 1'b0;
    if (!primed_q || resync) begin
      cnt_n = count;
    end else if (count != cnt_q) begin
      cnt_n = count;
      if (cnt_q == MAXC && count == '0) begin
        epoch_n  = epoch_q + EW'(1);
        push     = 1'b1;
        push_dir = 1'b1;
        push_ep  = epoch_n;
        set_ovf  = (epoch_q == MAXE);
      end else if (cnt_q == '0 && count == MAXC) begin
        epoch_n  = epoch_q - EW'(1);
        push     = 1'b1;
        push_dir = 1'b0;
        push_ep  = epoch_n;
        set_ovf  = (epoch_q == '0);
      end else if (count != cnt_q + CW'(1) && count != cnt_q - CW'(1)) begin
        set_step = 1'b1;
      end
    end
  end

  // FIFO bookkeeping; head outputs are registered and hold when empty
  always_comb begin
    pop       = evt_valid && evt_ready;
    full      = (occ == OW'(DEPTH));
    do_push   = push && (!full || pop);
    drop      = push && full && !pop;
    occ_n     = occ + OW'(do_push) - OW'(pop);
    rd_n      = rd_ptr + AW'(pop);
    wr_n      = wr_ptr + AW'(do_push);
    valid_n   = (occ_n != '0);
    dir_n     = evt_dir;
    head_ep_n = evt_epoch;
    if (occ_n != '0) begin
      // FIFO drained to nothing before this push: new entry is the head
      if (occ - OW'(pop) == '0) begin
        dir_n     = push_dir;
        head_ep_n = push_ep;
      end else begin
        {dir_n, head_ep_n} = mem[rd_n];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      epoch_q   <= '0;
      primed_q  <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occ       <= '0;
      evt_valid <= 1'b0;
      evt_dir   <= 1'b0;
      evt_epoch <= '0;
      step_err  <= 1'b0;
      epoch_ovf <= 1'b0;
      evt_drop  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      cnt_q     <= cnt_n;
      epoch_q   <= epoch_n;
      primed_q  <= 1'b1;
      rd_ptr    <= rd_n;
      wr_ptr    <= wr_n;
      occ       <= occ_n;
      evt_valid <= valid_n;
      evt_dir   <= dir_n;
      evt_epoch <= head_ep_n;
      // A set on the same edge as clr wins
      step_err  <= (step_err  && !clr) || set_step;
      epoch_ovf <= (epoch_ovf && !clr) || set_ovf;
      evt_drop  <= (evt_drop  && !clr) || drop;
      if (do_push) mem[wr_ptr] <= {push_dir, push_ep};
    end
  end

  assign ext_count = {epoch_q, cnt_q};

endmodule

// File: tb/tb_count_wrap_tracker.sv
module tb_count_wrap_tracker;

  typedef struct packed {
    logic       dir;
    logic [3:0] ep;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] count;
  logic       resync, clr, evt_ready;
  logic [7:0] ext_count;
  logic       evt_valid, evt_dir, step_err, epoch_ovf, evt_drop;
  logic [3:0] evt_epoch;

  int n_checks = 0;
  int n_fail   = 0;
  ev_t exp_q[$];

  count_wrap_tracker #(.CW(4), .EW(4), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .count(count), .resync(resync), .clr(clr),
    .ext_count(ext_count), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_dir(evt_dir), .evt_epoch(evt_epoch), .step_err(step_err),
    .epoch_ovf(epoch_ovf), .evt_drop(evt_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one sample, let one edge pass, return 1 time unit after it
  task automatic step(input logic [3:0] c, input logic rs);
    count  = c;
    resync = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input logic d, input logic [3:0] e);
    ev_t x;
    x.dir = d;
    x.ep  = e;
    exp_q.push_back(x);
  endtask

  // Monitor: on each accepted handshake compare the head against the scoreboard
  always @(negedge clk) begin
    if (reset && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got dir=%0d epoch=%0d expected none", evt_dir, evt_epoch);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("evt_dir",   32'(evt_dir),   32'(e.dir));
        chk("evt_epoch", 32'(evt_epoch), 32'(e.ep));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; count = '0; resync = 1'b0; clr = 1'b0; evt_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ext_count", 32'(ext_count), 32'h00);
    chk("rst_valid",     32'(evt_valid), 32'h0);
    chk("rst_dir",       32'(evt_dir),   32'h0);
    chk("rst_epoch",     32'(evt_epoch), 32'h0);
    chk("rst_flags",     32'({step_err, epoch_ovf, evt_drop}), 32'h0);
    reset = 1'b1;

    // Up wrap
    step(4'd14, 1'b0);
    chk("prime_ext", 32'(ext_count), 32'h0E);
    chk("prime_valid", 32'(evt_valid), 32'h0);
    step(4'd15, 1'b0);
    expect_ev(1'b1, 4'd1);
    step(4'd0, 1'b0);
    chk("upwrap_ext", 32'(ext_count), 32'h10);
    chk("upwrap_valid", 32'(evt_valid), 32'h1);
    chk("upwrap_head", 32'({evt_dir, evt_epoch}), 32'h11);
    step(4'd1, 1'b0);
    chk("upwrap_step_err", 32'(step_err), 32'h0);

    // Down wrap with consumer ready
    evt_ready = 1'b1;
    step(4'd1, 1'b0);
    step(4'd0, 1'b0);
    chk("dn_ext0", 32'(ext_count), 32'h10);
    expect_ev(1'b0, 4'd0);
    step(4'd15, 1'b0);
    chk("dn_ext_wrap", 32'(ext_count), 32'h0F);
    chk("dn_valid", 32'(evt_valid), 32'h1);
    step(4'd14, 1'b0);
    chk("dn_ext_next", 32'(ext_count), 32'h0E);
    chk("dn_popped", 32'(evt_valid), 32'h0);
    chk("dn_ovf", 32'(epoch_ovf), 32'h0);

    // Load jumps
    step(4'd3, 1'b1);
    step(4'd13, 1'b1);
    chk("resync_ext", 32'(ext_count), 32'h0D);
    chk("resync_step_err", 32'(step_err), 32'h0);
    chk("resync_valid", 32'(evt_valid), 32'h0);
    step(4'd3, 1'b1);
    step(4'd13, 1'b0);
    chk("jump_step_err", 32'(step_err), 32'h1);
    clr = 1'b1;
    step(4'd13, 1'b0);
    clr = 1'b0;
    chk("clr_step_err", 32'(step_err), 32'h0);
    chk("clr_keeps_ext", 32'(ext_count), 32'h0D);

    // FIFO full: five up wraps, fifth is dropped
    evt_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step(4'd15, 1'b1);
      if (i <= 4) expect_ev(1'b1, 4'(i));
      step(4'd0, 1'b0);
    end
    chk("full_valid", 32'(evt_valid), 32'h1);
    chk("full_drop", 32'(evt_drop), 32'h1);
    chk("full_head", 32'({evt_dir, evt_epoch}), 32'h11);
    chk("full_ext", 32'(ext_count), 32'h50);
    evt_ready = 1'b1;
    for (int i = 0; i < 5; i++) step(4'd0, 1'b0);
    chk("drain_valid", 32'(evt_valid), 32'h0);
    chk("drain_sb_empty", 32'(exp_q.size()), 32'h0);
    clr = 1'b1;
    step(4'd0, 1'b0);
    clr = 1'b0;
    chk("clr_drop", 32'(evt_drop), 32'h0);
    chk("empty_holds_head", 32'({evt_dir, evt_epoch}), 32'h14);

    // Full with simultaneous push/pop
    evt_ready = 1'b0;
    for (int i = 6; i <= 9; i++) begin
      step(4'd15, 1'b1);
      expect_ev(1'b1, 4'(i));
      step(4'd0, 1'b0);
    end
    step(4'd15, 1'b1);
    evt_ready = 1'b1;
    expect_ev(1'b1, 4'd10);
    step(4'd0, 1'b0);
    chk("pp_no_drop", 32'(evt_drop), 32'h0);
    chk("pp_head", 32'({evt_dir, evt_epoch}), 32'h17);
    for (int i = 0; i < 5; i++) step(4'd0, 1'b0);
    chk("pp_drain_valid", 32'(evt_valid), 32'h0);
    chk("pp_sb_empty", 32'(exp_q.size()), 32'h0);

    // Epoch overflow from a clean epoch 0
    reset = 1'b0;
    #1;
    reset = 1'b1;
    step(4'd15, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      expect_ev(1'b1, 4'(i));
      step(4'd0, 1'b0);
      if (i == 15) chk("ovf_before", 32'(epoch_ovf), 32'h0);
      if (i == 16) begin
        chk("ovf_set", 32'(epoch_ovf), 32'h1);
        chk("ovf_ext", 32'(ext_count), 32'h00);
      end
      step(4'd15, 1'b1);
    end
    chk("ovf_sb_empty", 32'(exp_q.size()), 32'h0);

    // Reset mid-stream with an event queued
    evt_ready = 1'b0;
    expect_ev(1'b1, 4'd1);
    step(4'd0, 1'b0);
    chk("pre_rst_valid", 32'(evt_valid), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_ext", 32'(ext_count), 32'h00);
    chk("mid_rst_valid", 32'(evt_valid), 32'h0);
    chk("mid_rst_head", 32'({evt_dir, evt_epoch}), 32'h00);
    chk("mid_rst_flags", 32'({step_err, epoch_ovf, evt_drop}), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    step(4'd15, 1'b0);
    chk("reprime_valid", 32'(evt_valid), 32'h0);
    chk("reprime_ext", 32'(ext_count), 32'h0F);
    chk("reprime_step_err", 32'(step_err), 32'h0);
    step(4'd15, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/count_wrap_tracker.md
Name: count_wrap_tracker

Overview:
- Downstream consumer of the 4-bit up/down counter output; samples `count` every clock.
- Detects wrap-around in both directions (MAX->0 up, 0->MAX down) and keeps a signed-free epoch register, giving an extended count {epoch, count}.
- Queues each wrap event in a small FIFO, drained through a valid/ready handshake.
- Flags illegal steps, epoch overflow and dropped events.

Parameters:
- CW, 4, counter width; MAX = 2^CW-1.
- EW, 4, epoch width; epoch arithmetic is modulo 2^EW.
- DEPTH, 4, event FIFO depth; power of two, >=2.

Ports:
- clk  input  1  rising-edge clock, same as the counter's.
- reset  input  1  asynchronous, active-low reset.
- count  input  CW  counter output, sampled each rising edge.
- resync  input  1  high = the count change seen at this edge is a load or counter reset, not a step.
- clr  input  1  synchronous clear of sticky flags only.
- ext_count  output  CW+EW  {epoch, cnt_q}.
- evt_valid  output  1  FIFO non-empty.
- evt_ready  input  1  consumer accepts the head entry.
- evt_dir  output  1  head entry direction: 1=up wrap, 0=down wrap.
- evt_epoch  output  EW  head entry epoch value after the wrap.
- step_err  output  1  sticky: non-resync change other than ±1 mod 2^CW.
- epoch_ovf  output  1  sticky: epoch wrapped MAXE->0 or 0->MAXE.
- evt_drop  output  1  sticky: event lost because FIFO full.

Behaviour:
- Reset (async assert, sync-released use): cnt_q=0, epoch=0, primed=0, FIFO empty, evt_valid=0, evt_dir=0, evt_epoch=0, all sticky flags 0, ext_count=0.
- First edge after reset (primed=0): cnt_q<=count, primed<=1; no event, no error check.
- Each later edge, priority order:
  - resync=1: cnt_q<=count; epoch, events and flags unchanged.
  - count==cnt_q: hold.
  - cnt_q==MAX and count==0: up wrap. epoch<=epoch+1; push {1, epoch+1}; if epoch==2^EW-1, set epoch_ovf.
  - cnt_q==0 and count==MAX: down wrap. epoch<=epoch-1; push {0, epoch-1}; if epoch==0, set epoch_ovf.
  - count==cnt_q±1 (no wrap): cnt_q<=count.
  - Any other change: cnt_q<=count, set step_err, epoch unchanged, no event.
- Latency: ext_count reflects `count` one edge after sampling. An event pushed at edge N gives evt_valid=1 after edge N when the FIFO was empty.
- FIFO:
  - First-word-fall-through; evt_dir and evt_epoch show the head entry while evt_valid=1.
  - Pop on an edge where evt_valid&&evt_ready. evt_ready with evt_valid=0 is ignored.
  - Push while full with no pop: entry discarded, evt_drop set, FIFO contents unchanged.
  - Push and pop on the same edge while full: both happen, no drop.
  - Push and pop on the same edge while empty cannot occur (evt_valid=0).
  - When empty, evt_dir and evt_epoch hold their last values (0 after reset).
  - Occupancy counter width log2(DEPTH)+1.
- clr=1: step_err, epoch_ovf and evt_drop go to 0 at the edge. A set condition on the same edge wins, so the flag stays 1. clr does not touch the FIFO, epoch or cnt_q.
- reset asserted mid-operation: everything returns immediately to reset values, including queued events. After release, the first edge re-primes.
- Events are produced only from registered compares; no combinational path from count to evt_*.

Test Plan:
- Reset, then count = 14, 15, 0, 1 (resync=0): first edge primes. At the 15->0 edge, epoch=1 and ext_count=0x10. One event {dir=1, epoch=1} with evt_valid=1; step_err=0.
- Down wrap: count = 1, 0, 15, 14 from epoch=1 with evt_ready=1: epoch=0, ext_count=0x0F then 0x0E. Event {0, 0} popped in one cycle.
- Load jump: count 3 -> 13 with resync=1: cnt_q=13, no event, step_err=0. Repeat with resync=0: step_err=1. Then clr=1 for one cycle: step_err=0.
- FIFO full: evt_ready=0, drive five up wraps: evt_valid=1, four entries with epochs 1..4, evt_drop=1. Then evt_ready=1: entries drain in order 1, 2, 3, 4, then evt_valid=0.
- Full plus simultaneous push/pop: with four entries queued and evt_ready=1 on the fifth wrap edge, no drop. Head advances and the new entry lands at the tail.
- Epoch overflow: sixteen consecutive up wraps from epoch=0: epoch 15->0 and epoch_ovf=1. Assert reset mid-stream: all outputs zero immediately; first post-reset edge produces no event.
